fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that drives the instruction memory and controls what is written into the fetch/decode pipeline register (instr, pc_inc, valid).
- Owns the PC and tolerates multi-cycle instruction-memory latency.
- Holds a fetched word when decode stalls, squashes wrong-path fetches on redirect, and stops fetching after HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPC, 5'b00000, value of instr[15:11] that marks HALT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  16  fetch address; held stable while a request is outstanding
- imem_rd  out  1  read request; held high until imem_done
- imem_data  in  16  instruction word; valid only when imem_done=1
- imem_done  in  1  one-cycle pulse: read complete
- imem_stall  in  1  request accepted, result pending
- fd_stall  in  1  decode cannot accept; FD register must hold
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  16  redirect target
- instr_out  out  16  d-input for the FD instr field
- pc_inc_out  out  16  d-input for the FD pc_inc field (fetch PC + 2)
- valid_out  out  1  d-input for the FD valid field
- fd_we  out  1  FD register write enable
- halted  out  1  high in HALT state

Behaviour:
- Registers: pc[15:0], tgt[15:0], buf_instr[15:0], buf_pcinc[15:0], buf_halt, state ∈ {FETCH, HOLD, DRAIN, HALT}. State encoding lives in the package.
- Reset (synchronous, rst=1 at the clk edge): pc=RESET_PC, state=FETCH, buffers cleared.
- While rst=1: imem_rd=0, fd_we=0, valid_out=0, halted=0.
- is_halt = (imem_data[15:11]==HALT_OPC). For the buffered word, buf_halt is used instead.
- Default each cycle: valid_out=0; fd_we=!fd_stall, so a bubble is written whenever FD is free; instr_out=imem_data; pc_inc_out=pc+2.
- Redirect flush, any state: fd_we=1 and valid_out=0, overriding fd_stall.
- Redirect priority: redirect beats imem_done and fd_stall in the same cycle.
- FETCH: imem_rd=1, imem_addr=pc.
  - redirect & imem_stall & !imem_done: tgt<=redirect_pc, go to DRAIN (pc unchanged, so the address stays stable).
  - redirect otherwise: pc<=redirect_pc, stay in FETCH. A same-cycle imem_done result is discarded.
  - imem_done & !fd_stall: valid_out=1, fd_we=1, pc<=pc+2. Go to HALT if is_halt, else stay in FETCH.
  - imem_done & fd_stall: buf_instr<=imem_data, buf_pcinc<=pc+2, buf_halt<=is_halt, pc<=pc+2, go to HOLD.
  - no done: stay, holding the request.
- HOLD: imem_rd=0; instr_out=buf_instr, pc_inc_out=buf_pcinc.
  - redirect: pc<=redirect_pc, go to FETCH (buffer dropped).
  - !fd_stall: valid_out=1, fd_we=1. Go to HALT if buf_halt, else FETCH.
  - else: stay.
- DRAIN: imem_rd=1, imem_addr=pc (the stale address).
  - redirect: tgt<=redirect_pc (latest target wins).
  - imem_done: result discarded, pc<=tgt (or redirect_pc if redirect is also asserted this cycle), go to FETCH.
- HALT: imem_rd=0, halted=1, bubbles written. redirect: pc<=redirect_pc, go to FETCH (an older branch cancels the HALT). Otherwise remain until rst.
- Arithmetic: pc+2 is modulo 2^16 (16'hFFFE+2 = 16'h0000).
- Latency: a hit (imem_done in the same cycle as the request) delivers one instruction per cycle. Instr_out/pc_inc_out/valid_out are combinational so the FD register captures at the same edge.
- Reset mid-operation: an outstanding memory request is abandoned. The memory system is reset by the same rst.

Decomposition:
- fetch_pkg (or a `define include): state encodings, HALT_OPC, RESET_PC, INSTR_W=16.
- One sub-module, fetch_buf: a 33-bit enable-loaded register (instr, pc_inc, halt flag) built from the codebase dff cells.
- FSM and PC stay in fetch_ctrl.

Test Plan:
- Reset then 3 hits (done every cycle, data 16'h4000, 16'h4001, 16'h4002):
  - imem_addr 0, 2, 4.
  - FD writes with valid=1, pc_inc 2, 4, 6.
- Miss: imem_stall=1 for 3 cycles then done with 16'h9A00:
  - imem_addr stays 0, fd_we=1 with valid=0 during the wait.
  - Instruction delivered with pc_inc=2, pc then 2.
- Done with fd_stall=1 for 2 cycles:
  - State goes to HOLD, fd_we=0, imem_rd=0.
  - On release, buffered word written with valid=1 and its original pc_inc; the next fetch address is +2.
- Redirect to 16'h0100 while imem_stall=1 at addr 4:
  - DRAIN keeps addr 4 until done; result discarded; the next request is 16'h0100.
  - A second redirect to 16'h0200 during DRAIN makes the next request 16'h0200.
- Fetch 16'h0000 (HALT) with fd_stall=0:
  - Written with valid=1, halted=1, imem_rd=0 thereafter.
  - redirect to 16'h0040 resumes fetch at 16'h0040.
- Redirect with fd_stall=1 and imem_done in the same cycle: fd_we=1, valid_out=0, data dropped, pc=redirect_pc.
- rst asserted in DRAIN: next cycle pc=0, FETCH, no stale write.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch-stage shared types and constants.
// State encoding and the 33-bit hold-buffer layout.
package fetch_pkg;

  localparam int INSTR_W = 16;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [4:0]  HALT_OPC_DEF = 5'b00000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [15:0]        pc_inc;
    logic               halt;
  } fbuf_t;

endpackage

// File: rtl/fetch_buf.sv
// Hold buffer for a fetched word that decode could not accept.
// Enable-loaded 33-bit register, cleared by reset.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  fbuf_t nxt,
  output fbuf_t cur
);

  // load on enable, clear on reset
  always_ff @(posedge clk) begin
    if (rst)
      cur <= '0;
    else if (en)
      cur <= nxt;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives imem, feeds the FD register.
// Holds on decode stall, drains wrong-path reads, stops on HALT.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [4:0]  HALT_OPC = HALT_OPC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        fd_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr_out,
  output logic [15:0] pc_inc_out,
  output logic        valid_out,
  output logic        fd_we,
  output logic        halted
);

  state_t      state;
  logic [15:0] pc;
  logic [15:0] tgt;
  logic [15:0] pc_nx2;
  logic        is_halt;
  logic        buf_we;
  fbuf_t       buf_nxt;
  fbuf_t       buf_cur;

  assign pc_nx2  = pc + 16'd2;
  assign is_halt = (imem_data[15:11] == HALT_OPC);
  assign buf_nxt = {imem_data, pc_nx2, is_halt};
  assign buf_we  = !rst && (state == S_FETCH) && !redirect
                 && imem_done && fd_stall;

  fetch_buf u_buf (
    .clk (clk),
    .rst (rst),
    .en  (buf_we),
    .nxt (buf_nxt),
    .cur (buf_cur)
  );

  // FD d-inputs and imem request, decoded from state
  always_comb begin
    imem_addr  = pc;
    imem_rd    = 1'b0;
    fd_we      = !fd_stall;
    valid_out  = 1'b0;
    instr_out  = imem_data;
    pc_inc_out = pc_nx2;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_rd = 1'b1;
        if (imem_done && !fd_stall) begin
          valid_out = 1'b1;
          fd_we     = 1'b1;
        end
      end
      S_HOLD: begin
        instr_out  = buf_cur.instr;
        pc_inc_out = buf_cur.pc_inc;
        if (!fd_stall) begin
          valid_out = 1'b1;
          fd_we     = 1'b1;
        end
      end
      S_DRAIN: imem_rd = 1'b1;
      S_HALT:  halted  = 1'b1;
      default: ;
    endcase
    if (redirect) begin
      fd_we     = 1'b1;
      valid_out = 1'b0;
    end
    if (rst) begin
      imem_rd   = 1'b0;
      fd_we     = 1'b0;
      valid_out = 1'b0;
      halted    = 1'b0;
    end
  end

  // PC, drain target and sequencer state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      tgt   <= '0;
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (redirect) begin
            if (imem_stall && !imem_done) begin
              tgt   <= redirect_pc;
              state <= S_DRAIN;
            end else begin
              pc <= redirect_pc;
            end
          end else if (imem_done) begin
            pc <= pc_nx2;
            if (fd_stall)
              state <= S_HOLD;
            else if (is_halt)
              state <= S_HALT;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= S_FETCH;
          end else if (!fd_stall) begin
            state <= buf_cur.halt ? S_HALT : S_FETCH;
          end
        end
        S_DRAIN: begin
          if (redirect)
            tgt <= redirect_pc;
          if (imem_done) begin
            pc    <= redirect ? redirect_pc : tgt;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
